// File: rtl/serial_divider.sv
// Sequential restoring divider: one quotient bit per clock, unsigned N-bit operands.
// A zero divisor completes in one cycle with an all-ones quotient and the dividend as remainder.
module serial_divider #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [N-1:0]  r_r, r_q, r_d;
  logic [CW-1:0] r_count;

  logic [N:0]    w_t, w_b, w_s;
  logic          w_nobrw, w_last, w_accept;
  logic [N-1:0]  w_new_r, w_new_q;

  // T - D formed as T + ~{0,D} + 1 with generate/propagate carry chain
  always_comb begin
    logic carry;
    w_t   = {r_r, r_q[N-1]};
    w_b   = ~{1'b0, r_d};
    w_s   = '0;
    carry = 1'b1;
    for (int unsigned i = 0; i < N + 1; i++) begin
      w_s[i] = w_t[i] ^ w_b[i] ^ carry;
      carry  = (w_t[i] & w_b[i]) | ((w_t[i] ^ w_b[i]) & carry);
    end
  end

  assign w_nobrw  = ~w_s[N];
  assign w_new_r  = w_nobrw ? w_s[N-1:0] : w_t[N-1:0];
  assign w_new_q  = {r_q[N-2:0], w_nobrw};
  assign w_last   = (r_count == CW'(N - 1));
  assign w_accept = start && (r_state != S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) w_next = (divisor == '0) ? S_DONE : S_RUN;
        else          w_next = S_IDLE;
      end
      S_RUN:   if (w_last) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r         <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_count     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (w_accept) begin
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        r_d     <= divisor;
        r_q     <= dividend;
        r_r     <= '0;
        r_count <= '0;
      end
    end else if (r_state == S_RUN) begin
      r_r     <= w_new_r;
      r_q     <= w_new_q;
      r_count <= r_count + CW'(1);
      if (w_last) begin
        quotient    <= w_new_q;
        remainder   <= w_new_r;
        div_by_zero <= 1'b0;
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_serial_divider.sv
// Self-checking bench for serial_divider: directed cases plus random operands
// against a cycle-level model built on plain / and % arithmetic.
module tb_serial_divider;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic [N-1:0] quotient, remainder;
  logic         busy, done, div_by_zero;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_divider #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Model: remaining-iteration counter plus results from integer division.
  int           m_left = 0;
  logic [N-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  logic         m_busy = 1'b0, m_done = 1'b0, m_z = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_q = '0; m_r = '0; m_z = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1; m_q = p_q; m_r = p_r; m_z = 1'b0;
        end
      end else if (start) begin
        if (divisor == '0) begin
          m_done = 1'b1; m_q = '1; m_r = dividend; m_z = 1'b1;
        end else begin
          m_left = N;
          p_q = dividend / divisor;
          p_r = dividend % divisor;
        end
      end
      m_busy = (m_left > 0);
    end
  end

  always @(negedge clk) begin
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("quotient", quotient, m_q);
    check("remainder", remainder, m_r);
    check("div_by_zero", div_by_zero, m_z);
  end

  // Called at posedge+1; start is raised so the next edge accepts it.
  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
    #1;
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = N'($urandom); divisor = N'($urandom);
  endtask

  task automatic wait_done(output int w);
    w = 0;
    while (done !== 1'b1 && w < 40) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 40) check("done_timeout", 0, 1);
  endtask

  task automatic op(input logic [N-1:0] a, input logic [N-1:0] b,
                    input logic [N-1:0] eq, input logic [N-1:0] er, input string nm);
    int w;
    launch(a, b);
    wait_done(w);
    check({nm, "_q"}, quotient, eq);
    check({nm, "_r"}, remainder, er);
  endtask

  initial begin
    int w;
    logic [N-1:0] a, b;
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_q", quotient, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    launch(8'd200, 8'd7);
    check("busy_after_accept", busy, 1);
    wait_done(w);
    check("latency_200_7", w, N);
    check("q_200_7", quotient, 28);
    check("r_200_7", remainder, 4);
    check("z_200_7", div_by_zero, 0);

    op(8'd255, 8'd1, 8'd255, 8'd0, "b255_1");
    op(8'd5, 8'd10, 8'd0, 8'd5, "b5_10");
    op(8'd255, 8'd255, 8'd1, 8'd0, "b255_255");
    op(8'd0, 8'd3, 8'd0, 8'd0, "b0_3");

    launch(8'd12, 8'd0);
    check("dz_busy", busy, 0);
    wait_done(w);
    check("dz_latency", w, 0);
    check("dz_q", quotient, 255);
    check("dz_r", remainder, 12);
    check("dz_flag", div_by_zero, 1);
    op(8'd25, 8'd7, 8'd3, 8'd4, "after_dz");
    check("dz_cleared", div_by_zero, 0);

    launch(8'd20, 8'd3);
    repeat (3) @(posedge clk);
    #2 dividend = 8'd100; divisor = 8'd10; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(w);
    check("ign_q", quotient, 6);
    check("ign_r", remainder, 2);

    launch(8'd20, 8'd3);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_q", quotient, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("arst_no_done", done, 0);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    op(8'd14, 8'd4, 8'd3, 8'd2, "post_rst");

    launch(8'd4, 8'd14);
    check("held_q", quotient, 3);
    check("b2b_busy", busy, 1);
    wait_done(w);
    check("b2b_q", quotient, 0);
    check("b2b_r", remainder, 4);

    for (int i = 0; i < 150; i++) begin
      a = N'($urandom);
      b = ($urandom_range(0, 9) == 0) ? '0 :
          (($urandom_range(0, 3) == 0) ? N'($urandom_range(1, 7)) : N'($urandom_range(1, 255)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      launch(a, b);
      if (b != '0 && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
      wait_done(w);
      if (b != '0) begin
        check("inv_eq", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
        check("inv_lt", 32'(remainder < b), 1);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
